if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of inst_rom.
- Owns the program counter and drives inst_rom's addr_in.
- Captures inst_rom's data_out into the IF/ID pipeline register for the decode stage.
- Handles sequential fetch, branch/jump redirect, stall and flush.
- Uses a small boot/run(/halt) state machine.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch
HALT_WORD, 32'h0000_000D, instruction word that triggers halt (used only with IF_HALT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
stall_i  input  1  hold PC and IF/ID contents
flush_i  input  1  squash IF/ID (insert bubble)
branch_taken_i  input  1  redirect PC to branch_target_i
branch_target_i  input  32  branch target byte address
jump_i  input  1  redirect PC to jump address
jump_index_i  input  26  J-type index field
rom_addr_o  output  32  to inst_rom addr_in
rom_data_i  input  32  from inst_rom data_out (combinational read, same cycle)
if_id_inst_o  output  32  latched instruction
if_id_pc4_o  output  32  latched PC+PC_STEP of that instruction
if_id_valid_o  output  1  IF/ID holds a real instruction
halted_o  output  1  fetch halted (tied 0 without IF_HALT_EN)

Behaviour:
Clock and reset:
- Single clock, clk.
- rst is asynchronous, active-low.
- rst low forces: PC=RESET_PC, state=S_BOOT, if_id_inst_o=0 (NOP), if_id_pc4_o=0, if_id_valid_o=0, halted_o=0.
- Reset asserted mid-operation discards all state immediately; no partial updates on the next edge.

Outputs:
- rom_addr_o = PC, combinational from the PC register.
- pc4 = PC + PC_STEP, modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

States:
- S_BOOT: exactly one cycle after reset release. PC holds, IF/ID stays invalid. Next state S_RUN. stall_i, flush_i and redirects are ignored here.
- S_RUN: normal fetch.
- S_HALT: with the macro only; see Optional Feature.

PC update in S_RUN, per rising edge, highest priority first:
1. branch_taken_i: PC <= {branch_target_i[31:2], 2'b00}.
2. jump_i: PC <= {if_id_pc4_o[31:28], jump_index_i, 2'b00}.
3. stall_i: PC holds.
4. Otherwise: PC <= pc4.

Redirect vs stall:
- A redirect overrides stall_i for the PC.
- Branch beats jump when both are asserted.

IF/ID update in S_RUN, per rising edge, highest priority first:
1. flush_i, branch_taken_i or jump_i: inst<=0, pc4<=0, valid<=0.
2. stall_i: hold all three.
3. Otherwise: inst<=rom_data_i, pc4<=pc4, valid<=1.

Timing and alignment:
- Latency: an instruction at address A appears on if_id_inst_o one edge after PC==A.
- First valid instruction appears 2 edges after reset release (boot cycle plus one fetch).
- PC[1:0] is always 0; redirect targets are forced aligned.

Optional Feature:
Macro: IF_HALT_EN
- Defined:
  - In S_RUN, when rom_data_i==HALT_WORD, the edge that latches it into IF/ID also enters S_HALT. The halt word itself is passed on with valid=1.
  - In S_HALT, from the next edge onward: PC frozen, valid<=0, inst<=0, halted_o=1.
  - stall_i, flush_i and redirects are ignored in S_HALT. Only rst exits.
  - If a redirect or flush coincides with the halt word, the redirect/flush wins and no halt occurs.
  - If stall coincides with the halt word, nothing is latched and no halt occurs yet.
- Undefined: no S_HALT state, halted_o tied 0, HALT_WORD ignored.

Test Plan:
- Reset/boot: hold rst low 2 cycles, release, no other inputs -> rom_addr_o=0 during boot. If_id_valid_o=0 until edge 2, then inst=ROM[0], pc4=4. rom_addr_o steps 0,4,8,... one per cycle.
- Stall: stall_i high 3 cycles while PC=0x10 -> rom_addr_o stays 0x10 and IF/ID holds the 0x0C instruction for 3 cycles. After release, PC goes to 0x14 and IF/ID loads the 0x10 instruction.
- Branch vs jump vs stall: at PC=0x20 assert branch_taken_i with target 0x0000_0041, jump_i and stall_i all at once -> next PC=0x40, next valid=0. Then ROM[0x40] is fetched normally.
- Jump: if_id_pc4_o=0x1000_0024, jump_index_i=26'h000_0010 -> next PC=0x1000_0040, IF/ID flushed.
- Flush and wrap: with PC=32'hFFFF_FFFC, pulse flush_i -> valid=0 next cycle, PC wraps to 0x0000_0000.
- Halt and reset mid-operation (IF_HALT_EN): place 32'h0000_000D at 0x08 -> IF/ID receives it with valid=1, then halted_o=1 and PC stays 0x0C. Drive rst low mid-halt -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses inst_rom and fills the IF/ID register.
// Optional halt-on-HALT_WORD support is compiled in with `define IF_HALT_EN.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned PC_STEP   = 4,
   parameter logic [31:0] HALT_WORD = 32'h0000_000D
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [25:0] jump_index_i,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i,
   output logic [31:0] if_id_inst_o,
   output logic [31:0] if_id_pc4_o,
   output logic        if_id_valid_o,
   output logic        halted_o
);

`ifdef IF_HALT_EN
   typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1} state_t;
`endif

   state_t      state, state_next;
   logic [31:0] pc, pc_next, pc4;
   logic [31:0] inst_next, pc4_next;
   logic        valid_next;
   logic        redirect;

   // Target low bits are discarded (alignment); HALT_WORD is idle without the halt option.
   logic        unused_bits;
   assign unused_bits = ^{branch_target_i[1:0], HALT_WORD};

   assign pc4        = pc + 32'(PC_STEP);
   assign rom_addr_o = pc;
   assign redirect   = branch_taken_i | jump_i;

`ifdef IF_HALT_EN
   assign halted_o = (state == S_HALT);
`else
   assign halted_o = 1'b0;
`endif

   // NOTE: every signal gets a hold/default value first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      inst_next  = if_id_inst_o;
      pc4_next   = if_id_pc4_o;
      valid_next = if_id_valid_o;
      case (state)
         S_BOOT: state_next = S_RUN;
         S_RUN: begin
            if (branch_taken_i)
               pc_next = {branch_target_i[31:2], 2'b00};
            else if (jump_i)
               pc_next = {if_id_pc4_o[31:28], jump_index_i, 2'b00};
            else if (!stall_i)
               pc_next = pc4;

            if (flush_i || redirect) begin
               inst_next  = '0;
               pc4_next   = '0;
               valid_next = 1'b0;
            end else if (!stall_i) begin
               inst_next  = rom_data_i;
               pc4_next   = pc4;
               valid_next = 1'b1;
`ifdef IF_HALT_EN
               // The halt word itself still goes downstream as a valid instruction.
               if (rom_data_i == HALT_WORD)
                  state_next = S_HALT;
`endif
            end
         end
`ifdef IF_HALT_EN
         S_HALT: begin
            inst_next  = '0;
            valid_next = 1'b0;
         end
`endif
         default: state_next = S_BOOT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_BOOT;
         pc            <= RESET_PC;
         if_id_inst_o  <= '0;
         if_id_pc4_o   <= '0;
         if_id_valid_o <= 1'b0;
      end else begin
         state         <= state_next;
         pc            <= pc_next;
         if_id_inst_o  <= inst_next;
         if_id_pc4_o   <= pc4_next;
         if_id_valid_o <= valid_next;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic
// compared every cycle against a behavioural fetch model with a hashed ROM image.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        branch_taken_i = 1'b0;
   logic [31:0] branch_target_i = '0;
   logic        jump_i = 1'b0;
   logic [25:0] jump_index_i = '0;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_i;
   logic [31:0] if_id_inst_o;
   logic [31:0] if_id_pc4_o;
   logic        if_id_valid_o;
   logic        halted_o;

   logic [31:0] rom_seed = 32'h1234_5678;
   logic        halt_plant = 1'b0;

   int total = 0;
   int bad   = 0;

   // model state
   logic [31:0] m_pc, m_inst, m_pc4;
   logic        m_valid, m_boot, m_halt;

   if_fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .jump_i          (jump_i),
      .jump_index_i    (jump_index_i),
      .rom_addr_o      (rom_addr_o),
      .rom_data_i      (rom_data_i),
      .if_id_inst_o    (if_id_inst_o),
      .if_id_pc4_o     (if_id_pc4_o),
      .if_id_valid_o   (if_id_valid_o),
      .halted_o        (halted_o)
   );

   always #5 clk = ~clk;

   // ROM image: address hash, never the halt word unless it is deliberately planted at 0x08.
   function automatic logic [31:0] rom_fn(input logic [31:0] a, input logic [31:0] seed, input logic plant);
      logic [31:0] w;
      w = (a * 32'h9E37_79B9) ^ seed;
      if (w == 32'h0000_000D) w = 32'h0000_000E;
      if (plant && a == 32'h0000_0008) w = 32'h0000_000D;
      return w;
   endfunction

   assign rom_data_i = rom_fn(rom_addr_o, rom_seed, halt_plant);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_inst = '0; m_pc4 = '0; m_valid = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
   endtask

   task automatic compare_all();
      check("rom_addr", rom_addr_o, m_pc);
      check("inst", if_id_inst_o, m_inst);
      check("pc4", if_id_pc4_o, m_pc4);
      check("valid", 32'(if_id_valid_o), 32'(m_valid));
      check("halted", 32'(halted_o), 32'(m_halt));
   endtask

   // One clock: compare at the falling edge, then advance the model over the rising edge.
   task automatic cycle();
      logic [31:0] n_pc, n_inst, n_pc4, word;
      logic        n_valid, n_halt;
      @(negedge clk);
      compare_all();
      n_pc = m_pc; n_inst = m_inst; n_pc4 = m_pc4; n_valid = m_valid; n_halt = m_halt;
      word = rom_fn(m_pc, rom_seed, halt_plant);
      if (m_boot) begin
         // boot cycle: nothing moves
      end else if (m_halt) begin
         n_inst = '0; n_valid = 1'b0;
      end else begin
         if (branch_taken_i)  n_pc = branch_target_i & 32'hFFFF_FFFC;
         else if (jump_i)     n_pc = {m_pc4[31:28], jump_index_i, 2'b00};
         else if (!stall_i)   n_pc = m_pc + 32'd4;
         if (flush_i || branch_taken_i || jump_i) begin
            n_inst = '0; n_pc4 = '0; n_valid = 1'b0;
         end else if (!stall_i) begin
            n_inst = word; n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
`ifdef IF_HALT_EN
            if (word == 32'h0000_000D) n_halt = 1'b1;
`endif
         end
      end
      @(posedge clk);
      #1;
      m_boot = 1'b0;
      m_pc = n_pc; m_inst = n_inst; m_pc4 = n_pc4; m_valid = n_valid; m_halt = n_halt;
   endtask

   task automatic idle_inputs();
      stall_i = 1'b0; flush_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0;
   endtask

   // Asynchronous reset between edges; outputs must drop before any clock arrives.
   task automatic async_reset();
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("async_rst_addr", rom_addr_o, 32'h0);
      check("async_rst_inst", if_id_inst_o, 32'h0);
      check("async_rst_pc4", if_id_pc4_o, 32'h0);
      check("async_rst_valid", 32'(if_id_valid_o), 32'h0);
      check("async_rst_halted", 32'(halted_o), 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      rom_seed = $urandom;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst = 1'b1;

      // boot then sequential fetch
      cycle();
      check("boot_addr", rom_addr_o, 32'h0);
      check("boot_valid", 32'(if_id_valid_o), 32'h0);
      cycle();
      check("first_valid", 32'(if_id_valid_o), 32'h1);
      check("first_inst", if_id_inst_o, rom_fn(32'h0, rom_seed, 1'b0));
      check("first_pc4", if_id_pc4_o, 32'h4);
      repeat (3) cycle();
      check("seq_addr", rom_addr_o, 32'h10);

      // stall three cycles at PC 0x10
      stall_i = 1'b1;
      repeat (3) cycle();
      check("stall_addr", rom_addr_o, 32'h10);
      check("stall_inst", if_id_inst_o, rom_fn(32'hC, rom_seed, 1'b0));
      stall_i = 1'b0;
      cycle();
      check("unstall_addr", rom_addr_o, 32'h14);
      check("unstall_inst", if_id_inst_o, rom_fn(32'h10, rom_seed, 1'b0));
      repeat (3) cycle();

      // branch + jump + stall together at PC 0x20
      check("pre_branch_addr", rom_addr_o, 32'h20);
      branch_taken_i = 1'b1; branch_target_i = 32'h0000_0041;
      jump_i = 1'b1; jump_index_i = 26'h3FF_FFFF; stall_i = 1'b1;
      cycle();
      idle_inputs();
      check("branch_addr", rom_addr_o, 32'h40);
      check("branch_valid", 32'(if_id_valid_o), 32'h0);
      cycle();
      check("branch_fetch", if_id_inst_o, rom_fn(32'h40, rom_seed, 1'b0));

      // jump using the latched pc4 upper nibble
      branch_taken_i = 1'b1; branch_target_i = 32'h1000_0020;
      cycle();
      idle_inputs();
      cycle();
      check("jump_src_pc4", if_id_pc4_o, 32'h1000_0024);
      jump_i = 1'b1; jump_index_i = 26'h000_0010;
      cycle();
      idle_inputs();
      check("jump_addr", rom_addr_o, 32'h1000_0040);
      check("jump_valid", 32'(if_id_valid_o), 32'h0);

      // flush at the top of the address space, PC wraps
      branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFF;
      cycle();
      idle_inputs();
      check("wrap_pre_addr", rom_addr_o, 32'hFFFF_FFFC);
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      check("wrap_addr", rom_addr_o, 32'h0);
      check("flush_valid", 32'(if_id_valid_o), 32'h0);
      cycle();

      // halt word planted at 0x08
      async_reset();
      halt_plant = 1'b1;
      repeat (4) cycle();
`ifdef IF_HALT_EN
      check("halt_word", if_id_inst_o, 32'h0000_000D);
      check("halt_word_valid", 32'(if_id_valid_o), 32'h1);
      stall_i = 1'b1; flush_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h100;
      cycle();
      check("halted", 32'(halted_o), 32'h1);
      check("halt_addr", rom_addr_o, 32'h0C);
      cycle();
      check("halt_hold_addr", rom_addr_o, 32'h0C);
      idle_inputs();
`else
      check("no_halt", 32'(halted_o), 32'h0);
      repeat (2) cycle();
`endif
      async_reset();
      halt_plant = 1'b0;

      // randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         stall_i         = ($urandom_range(0, 3) == 0);
         flush_i         = ($urandom_range(0, 9) == 0);
         branch_taken_i  = ($urandom_range(0, 7) == 0);
         branch_target_i = $urandom;
         jump_i          = ($urandom_range(0, 9) == 0);
         jump_index_i    = 26'($urandom);
         if ($urandom_range(0, 39) == 0) async_reset();
         else cycle();
      end
      idle_inputs();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
